// File: rtl/rv32i_cdb_arbiter.sv
// Common data bus write-back arbiter.
// Collects results from NUM_SRC processing units into 1-entry slots and
// broadcasts one per cycle, round-robin, through a registered output stage.
// Optional build macro: RV32I_CDB_BYPASS_EN (empty-arbiter 1-cycle bypass).

package rv32i_pkg;
  parameter int unsigned REG_FILE_BW          = 32;
  parameter int unsigned PHYS_REG_FILE_IDX_BW = 6;
endpackage

module rv32i_cdb_arbiter
  import rv32i_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned ROB_IDX_BW = 4
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic                                          i_flush,
  input  logic [NUM_SRC-1:0]                            i_src_vld,
  input  logic [NUM_SRC-1:0][PHYS_REG_FILE_IDX_BW-1:0]  i_src_tag,
  input  logic [NUM_SRC-1:0][REG_FILE_BW-1:0]           i_src_wdata,
  input  logic [NUM_SRC-1:0][ROB_IDX_BW-1:0]            i_src_rob_idx,
  output logic [NUM_SRC-1:0]                            o_src_rdy,
  output logic                                          o_write_back,
  output logic [PHYS_REG_FILE_IDX_BW-1:0]               o_phys_rf_wr_idx,
  output logic [REG_FILE_BW-1:0]                        o_wdata,
  output logic [ROB_IDX_BW-1:0]                         o_rob_entry_idx,
  output logic                                          o_busy
);

  localparam int unsigned PTR_BW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  // Holding slots
  logic [NUM_SRC-1:0]                           slot_vld_q, slot_vld_d;
  logic [NUM_SRC-1:0][PHYS_REG_FILE_IDX_BW-1:0] slot_tag_q, slot_tag_d;
  logic [NUM_SRC-1:0][REG_FILE_BW-1:0]          slot_wdata_q, slot_wdata_d;
  logic [NUM_SRC-1:0][ROB_IDX_BW-1:0]           slot_rob_q, slot_rob_d;

  // Round-robin pointer and broadcast register
  logic [PTR_BW-1:0]               rr_ptr_q, rr_ptr_d;
  logic                            wb_q, wb_d;
  logic [PHYS_REG_FILE_IDX_BW-1:0] out_tag_q, out_tag_d;
  logic [REG_FILE_BW-1:0]          out_wdata_q, out_wdata_d;
  logic [ROB_IDX_BW-1:0]           out_rob_q, out_rob_d;

  logic                            grant_vld;
  logic [PTR_BW-1:0]               grant_idx;
  logic [NUM_SRC-1:0]              grant_oh;
  logic [NUM_SRC-1:0]              slot_wr;

  // Returns {found, index} of the first set request starting at ptr, wrapping.
  function automatic logic [PTR_BW:0] rr_pick(input logic [NUM_SRC-1:0] req,
                                              input logic [PTR_BW-1:0]  ptr);
    logic [PTR_BW:0]   res;
    logic [PTR_BW-1:0] ci;
    res = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      ci = PTR_BW'((32'(ptr) + i) % NUM_SRC);
      if (!res[PTR_BW] && req[ci]) res = {1'b1, ci};
    end
    return res;
  endfunction

  function automatic logic [PTR_BW-1:0] ptr_after(input logic [PTR_BW-1:0] idx);
    return PTR_BW'((32'(idx) + 1) % NUM_SRC);
  endfunction

  // Round-robin grant over occupied slots
  always_comb begin
    grant_oh              = '0;
    {grant_vld, grant_idx} = rr_pick(slot_vld_q, rr_ptr_q);
    if (grant_vld) grant_oh[grant_idx] = 1'b1;
  end

`ifdef RV32I_CDB_BYPASS_EN
  logic              bp_found;
  logic [PTR_BW-1:0] bp_idx;
  logic              bp_take;

  // Bypass candidate: highest-priority presenting source when every slot is empty
  always_comb begin
    {bp_found, bp_idx} = rr_pick(i_src_vld, rr_ptr_q);
    bp_take            = bp_found & ~|slot_vld_q & ~i_flush;
  end
`endif

  // Ready: slot empty or being drained this cycle; nothing is accepted during flush
  always_comb begin
    o_src_rdy = '0;
    for (int unsigned s = 0; s < NUM_SRC; s++)
      o_src_rdy[s] = ~i_flush & (~slot_vld_q[s] | grant_oh[s]);
  end

  // Slot, pointer and broadcast next-state
  always_comb begin
    slot_vld_d   = slot_vld_q;
    slot_tag_d   = slot_tag_q;
    slot_wdata_d = slot_wdata_q;
    slot_rob_d   = slot_rob_q;
    rr_ptr_d     = rr_ptr_q;
    wb_d         = 1'b0;
    out_tag_d    = out_tag_q;
    out_wdata_d  = out_wdata_q;
    out_rob_d    = out_rob_q;
    slot_wr      = i_src_vld & o_src_rdy;
    if (i_flush) begin
      slot_vld_d = '0;
    end else begin
`ifdef RV32I_CDB_BYPASS_EN
      // Bypassed source skips its slot; grant path is idle since all slots are empty
      if (bp_take) begin
        wb_d             = 1'b1;
        out_tag_d        = i_src_tag[bp_idx];
        out_wdata_d      = i_src_wdata[bp_idx];
        out_rob_d        = i_src_rob_idx[bp_idx];
        rr_ptr_d         = ptr_after(bp_idx);
        slot_wr[bp_idx]  = 1'b0;
      end
`endif
      if (grant_vld) begin
        wb_d                  = 1'b1;
        out_tag_d             = slot_tag_q[grant_idx];
        out_wdata_d           = slot_wdata_q[grant_idx];
        out_rob_d             = slot_rob_q[grant_idx];
        slot_vld_d[grant_idx] = 1'b0;
        rr_ptr_d              = ptr_after(grant_idx);
      end
      // Refill after drain so a same-edge accept overwrites the granted slot
      for (int unsigned s = 0; s < NUM_SRC; s++) begin
        if (slot_wr[s]) begin
          slot_vld_d[s]   = 1'b1;
          slot_tag_d[s]   = i_src_tag[s];
          slot_wdata_d[s] = i_src_wdata[s];
          slot_rob_d[s]   = i_src_rob_idx[s];
        end
      end
    end
  end

  // State registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_vld_q   <= '0;
      slot_tag_q   <= '0;
      slot_wdata_q <= '0;
      slot_rob_q   <= '0;
      rr_ptr_q     <= '0;
      wb_q         <= 1'b0;
      out_tag_q    <= '0;
      out_wdata_q  <= '0;
      out_rob_q    <= '0;
    end else begin
      slot_vld_q   <= slot_vld_d;
      slot_tag_q   <= slot_tag_d;
      slot_wdata_q <= slot_wdata_d;
      slot_rob_q   <= slot_rob_d;
      rr_ptr_q     <= rr_ptr_d;
      wb_q         <= wb_d;
      out_tag_q    <= out_tag_d;
      out_wdata_q  <= out_wdata_d;
      out_rob_q    <= out_rob_d;
    end
  end

  assign o_write_back     = wb_q;
  assign o_phys_rf_wr_idx = out_tag_q;
  assign o_wdata          = out_wdata_q;
  assign o_rob_entry_idx  = out_rob_q;
  assign o_busy           = |slot_vld_q | wb_q;

endmodule

// File: tb/tb_rv32i_cdb_arbiter.sv
// Self-checking bench for rv32i_cdb_arbiter (NUM_SRC=4, ROB_IDX_BW=4).
module tb_rv32i_cdb_arbiter;

  localparam int N = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 i_flush;
  logic [N-1:0]         i_src_vld;
  logic [N-1:0][5:0]    i_src_tag;
  logic [N-1:0][31:0]   i_src_wdata;
  logic [N-1:0][3:0]    i_src_rob_idx;
  logic [N-1:0]         o_src_rdy;
  logic                 o_write_back;
  logic [5:0]           o_phys_rf_wr_idx;
  logic [31:0]          o_wdata;
  logic [3:0]           o_rob_entry_idx;
  logic                 o_busy;

  int checks   = 0;
  int failures = 0;

  // Reference model: per-source pending result, rotating priority, output latch
  bit        m_full [N];
  bit [5:0]  m_tag  [N];
  bit [31:0] m_wd   [N];
  bit [3:0]  m_rob  [N];
  int        m_rr;
  bit        m_wb;
  bit [5:0]  m_otag;
  bit [31:0] m_owd;
  bit [3:0]  m_orob;

  rv32i_cdb_arbiter #(.NUM_SRC(4), .ROB_IDX_BW(4)) dut (
    .clk(clk), .rst(rst), .i_flush(i_flush),
    .i_src_vld(i_src_vld), .i_src_tag(i_src_tag), .i_src_wdata(i_src_wdata),
    .i_src_rob_idx(i_src_rob_idx), .o_src_rdy(o_src_rdy),
    .o_write_back(o_write_back), .o_phys_rf_wr_idx(o_phys_rf_wr_idx),
    .o_wdata(o_wdata), .o_rob_entry_idx(o_rob_entry_idx), .o_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < N; s++) begin
      m_full[s] = 0; m_tag[s] = '0; m_wd[s] = '0; m_rob[s] = '0;
    end
    m_rr = 0; m_wb = 0; m_otag = '0; m_owd = '0; m_orob = '0;
  endtask

  task automatic set_payload(input int s, input logic [5:0] t, input logic [31:0] w,
                             input logic [3:0] r);
    i_src_tag[s] = t; i_src_wdata[s] = w; i_src_rob_idx[s] = r;
  endtask

  task automatic rand_payload();
    for (int s = 0; s < N; s++)
      set_payload(s, 6'($urandom), $urandom, 4'($urandom));
  endtask

  // One clock: drive inputs, compare every output with the model, advance the model.
  // Called and returns 1 time unit after a rising edge.
  task automatic cycle(input logic [N-1:0] vld, input logic flush);
    int     g, bp;
    bit     any;
    logic [N-1:0] erdy;
    i_src_vld = vld;
    i_flush   = flush;
    #2;
    g = -1;
    for (int i = 0; i < N; i++)
      if (g < 0 && m_full[(m_rr + i) % N]) g = (m_rr + i) % N;
    for (int s = 0; s < N; s++) erdy[s] = !flush && (!m_full[s] || g == s);
    any = 0;
    for (int s = 0; s < N; s++) any |= m_full[s];
    chk("src_rdy",  64'(o_src_rdy),        64'(erdy));
    chk("write_back", 64'(o_write_back),   64'(m_wb));
    chk("tag",      64'(o_phys_rf_wr_idx), 64'(m_otag));
    chk("wdata",    64'(o_wdata),          64'(m_owd));
    chk("rob",      64'(o_rob_entry_idx),  64'(m_orob));
    chk("busy",     64'(o_busy),           64'(any || m_wb));
    if (flush) begin
      for (int s = 0; s < N; s++) m_full[s] = 0;
      m_wb = 0;
    end else begin
      bp = -1;
`ifdef RV32I_CDB_BYPASS_EN
      if (!any)
        for (int i = 0; i < N; i++)
          if (bp < 0 && vld[(m_rr + i) % N]) bp = (m_rr + i) % N;
`endif
      if (bp >= 0) begin
        m_wb = 1; m_otag = i_src_tag[bp]; m_owd = i_src_wdata[bp]; m_orob = i_src_rob_idx[bp];
        m_rr = (bp + 1) % N;
      end else if (g >= 0) begin
        m_wb = 1; m_otag = m_tag[g]; m_owd = m_wd[g]; m_orob = m_rob[g];
        m_full[g] = 0;
        m_rr = (g + 1) % N;
      end else begin
        m_wb = 0;
      end
      for (int s = 0; s < N; s++)
        if (vld[s] && erdy[s] && s != bp) begin
          m_full[s] = 1; m_tag[s] = i_src_tag[s]; m_wd[s] = i_src_wdata[s];
          m_rob[s] = i_src_rob_idx[s];
        end
    end
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse placed between clock edges
  task automatic async_reset(input string name);
    #2;
    rst = 1'b1;
    i_src_vld = '0;
    i_flush = 1'b0;
    #1;
    chk({name, "_wb"},   64'(o_write_back),     64'(0));
    chk({name, "_tag"},  64'(o_phys_rf_wr_idx), 64'(0));
    chk({name, "_wd"},   64'(o_wdata),          64'(0));
    chk({name, "_rob"},  64'(o_rob_entry_idx),  64'(0));
    chk({name, "_rdy"},  64'(o_src_rdy),        64'(4'b1111));
    chk({name, "_busy"}, 64'(o_busy),           64'(0));
    model_reset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [5:0] prev_tag;
    bit       have_prev;
    rst = 1'b1; i_flush = 1'b0; i_src_vld = '0;
    i_src_tag = '0; i_src_wdata = '0; i_src_rob_idx = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Single source 1 result
    set_payload(1, 6'h0c, 32'hbbbbaaaa, 4'd3);
    cycle(4'b0010, 1'b0);
`ifndef RV32I_CDB_BYPASS_EN
    chk("t1_no_early_wb", 64'(o_write_back), 64'(0));
    cycle(4'b0000, 1'b0);
`endif
    chk("t1_wb",    64'(o_write_back),     64'(1));
    chk("t1_tag",   64'(o_phys_rf_wr_idx), 64'(6'h0c));
    chk("t1_wdata", 64'(o_wdata),          64'(32'hbbbbaaaa));
    chk("t1_rob",   64'(o_rob_entry_idx),  64'(3));
    cycle(4'b0000, 1'b0);
    chk("t1_pulse", 64'(o_write_back),     64'(0));
    chk("t1_hold",  64'(o_wdata),          64'(32'hbbbbaaaa));
    // Next single result from src 1 must wait behind nothing: rr points at 2
    async_reset("rst_a");

    // All four sources at once after reset: order 0,1,2,3
    for (int s = 0; s < N; s++) set_payload(s, 6'(s), 32'h1000 + 32'(s), 4'(s + 8));
    cycle(4'b1111, 1'b0);
    i_src_tag = '0;
`ifndef RV32I_CDB_BYPASS_EN
    cycle(4'b0000, 1'b0);
`endif
    for (int k = 0; k < N; k++) begin
      chk("t2_wb",    64'(o_write_back),     64'(1));
      chk("t2_order", 64'(o_phys_rf_wr_idx), 64'(k));
      cycle(4'b0000, 1'b0);
    end
    chk("t2_done", 64'(o_write_back), 64'(0));

    // Sources 0 and 2 continuously: alternation
    have_prev = 0;
    for (int k = 0; k < 20; k++) begin
      set_payload(0, 6'd0, 32'h0a000000 + 32'(k), 4'd1);
      set_payload(2, 6'd2, 32'h0c000000 + 32'(k), 4'd2);
      cycle(4'b0101, 1'b0);
      if (o_write_back) begin
        if (have_prev) chk("t3_alt", 64'(o_phys_rf_wr_idx), 64'(prev_tag == 0 ? 2 : 0));
        prev_tag = o_phys_rf_wr_idx;
        have_prev = 1;
      end
    end
    repeat (4) cycle(4'b0000, 1'b0);

    // Slot 1 refilled in its own grant cycle
    async_reset("rst_b");
    set_payload(0, 6'h10, 32'h00000010, 4'd0);
    set_payload(1, 6'h11, 32'h11111111, 4'd1);
    cycle(4'b0011, 1'b0);
    cycle(4'b0000, 1'b0);
    set_payload(1, 6'h21, 32'hdaddad00, 4'd5);
    cycle(4'b0010, 1'b0);
    repeat (4) cycle(4'b0000, 1'b0);

    // Flush with three slots full
    rand_payload();
    cycle(4'b0111, 1'b0);
    cycle(4'b0000, 1'b1);
    chk("t5_wb",   64'(o_write_back), 64'(0));
    chk("t5_busy", 64'(o_busy),       64'(0));
    set_payload(3, 6'h33, 32'h33333333, 4'd7);
    repeat (2) cycle(4'b1000, 1'b0);
    repeat (3) cycle(4'b0000, 1'b0);

    // Reset mid-burst
    rand_payload();
    cycle(4'b1111, 1'b0);
    cycle(4'b1111, 1'b0);
    async_reset("rst_c");
    for (int s = 0; s < N; s++) set_payload(s, 6'(s + 40), $urandom, 4'(s));
    repeat (6) cycle(4'b1111 & 4'($urandom), 1'b0);

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      rand_payload();
      cycle(4'($urandom), ($urandom_range(0, 15) == 0));
    end
    repeat (6) cycle(4'b0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
